// File: rtl/scoreboard_pkg.sv
// Shared state encodings, widths and helpers for the scoreboard game sequencer.
package scoreboard_pkg;

   localparam int unsigned SEC_W  = 10;
   localparam int unsigned SHOT_W = 5;
   localparam int unsigned QTR_W  = 3;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StRun   = 3'd1,
      StPause = 3'd2,
      StBreak = 3'd3,
      StFinal = 3'd4
   } game_state_e;

   // Period number advances by one and sticks at its maximum (7).
   function automatic logic [QTR_W-1:0] qtr_sat_inc(input logic [QTR_W-1:0] q);
      return (q == '1) ? q : q + QTR_W'(1);
   endfunction

endpackage

// File: rtl/buzzer_timer.sv
// Buzzer on-time counter: a trigger (re)loads BUZZ_SEC, each tick counts it down.
module buzzer_timer #(
   parameter int unsigned BUZZ_SEC = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic trigger,
   input  logic tick_1hz,
   output logic buzzer
);

   localparam int unsigned CntW = (BUZZ_SEC < 2) ? 1 : $clog2(BUZZ_SEC + 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            buzzer_q, buzzer_d;

   // Retrigger has priority over the tick countdown.
   always_comb begin
      cnt_d = cnt_q;
      if (trigger) begin
         cnt_d = CntW'(BUZZ_SEC);
      end else if (tick_1hz && (cnt_q != '0)) begin
         cnt_d = cnt_q - CntW'(1);
      end
      buzzer_d = (cnt_d != '0);
   end

   // Counter and registered buzzer output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         buzzer_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         buzzer_q <= buzzer_d;
      end
   end

   assign buzzer = buzzer_q;

endmodule

// File: rtl/game_period_controller.sv
// Basketball game sequencer: period clock, quarter, possession and shot clock.
// Optional overtime on tied scores is enabled by defining GAME_OVERTIME_EN.
module game_period_controller
   import scoreboard_pkg::*;
#(
   parameter int unsigned QUARTER_SEC  = 600,
   parameter int unsigned NUM_QUARTERS = 4,
   parameter int unsigned BREAK_SEC    = 60,
   parameter int unsigned SHOT_SEC     = 24,
   parameter int unsigned OT_SEC       = 300,
   parameter int unsigned BUZZ_SEC     = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tick_1hz,
   input  logic              btn_start,
   input  logic              btn_poss_swap,
   input  logic              btn_shot_rst,
   input  logic [7:0]        score_a,
   input  logic [7:0]        score_b,
   output logic [SEC_W-1:0]  game_sec_left,
   output logic [QTR_W-1:0]  quarter,
   output logic [SHOT_W-1:0] shot_clock,
   output logic              poss_b,
   output logic              running,
   output logic              shot_violation,
   output logic              buzzer,
   output logic [2:0]        state
);

   game_state_e       state_q, state_d;
   logic [SEC_W-1:0]  game_q, game_d;
   logic [QTR_W-1:0]  quarter_q, quarter_d;
   logic [SHOT_W-1:0] shot_q, shot_d;
   logic              poss_q, poss_d;
   logic              viol_q, viol_d;
   logic              running_q, running_d;
   logic              buzz_trig;
   logic              period_end;
   logic              ot_tie;

`ifdef GAME_OVERTIME_EN
   assign ot_tie = (score_a == score_b);
`else
   logic unused_scores;
   assign ot_tie        = 1'b0;
   assign unused_scores = ^{score_a, score_b};
`endif

   // Next-state and counter updates for the game flow.
   always_comb begin
      state_d    = state_q;
      game_d     = game_q;
      quarter_d  = quarter_q;
      shot_d     = shot_q;
      poss_d     = poss_q;
      viol_d     = 1'b0;
      buzz_trig  = 1'b0;
      period_end = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (btn_start) state_d = StRun;
         end
         StRun: begin
            if (btn_start) begin
               // Pause wins over a simultaneous tick.
               state_d = StPause;
            end else if (tick_1hz) begin
               if (game_q == SEC_W'(1)) begin
                  period_end = 1'b1;
                  buzz_trig  = 1'b1;
                  game_d     = '0;
                  if (shot_q != '0) shot_d = shot_q - SHOT_W'(1);
                  if ((quarter_q < QTR_W'(NUM_QUARTERS)) || ot_tie) begin
                     state_d = StBreak;
                     game_d  = SEC_W'(BREAK_SEC);
                  end else begin
                     state_d = StFinal;
                  end
               end else begin
                  if (game_q != '0) game_d = game_q - SEC_W'(1);
                  if (shot_q == SHOT_W'(1)) begin
                     viol_d    = 1'b1;
                     poss_d    = ~poss_q;
                     shot_d    = SHOT_W'(SHOT_SEC);
                     buzz_trig = 1'b1;
                     state_d   = StPause;
                  end else if (shot_q != '0) begin
                     shot_d = shot_q - SHOT_W'(1);
                  end
               end
            end
         end
         StPause: begin
            if (btn_start) state_d = StRun;
         end
         StBreak: begin
            if (tick_1hz) begin
               if (game_q == SEC_W'(1)) begin
                  state_d   = StPause;
                  quarter_d = qtr_sat_inc(quarter_q);
                  // Past regulation, the next period is an overtime.
                  game_d    = (quarter_q >= QTR_W'(NUM_QUARTERS)) ? SEC_W'(OT_SEC)
                                                                  : SEC_W'(QUARTER_SEC);
                  shot_d    = SHOT_W'(SHOT_SEC);
                  // Odd old period -> B gets the ball: alternates by period.
                  poss_d    = quarter_q[0];
               end else if (game_q != '0) begin
                  game_d = game_q - SEC_W'(1);
               end
            end
         end
         StFinal: ;
         default: state_d = StIdle;
      endcase

      // Possession/shot buttons only act while a period is live.
      if (((state_q == StRun) || (state_q == StPause)) && !period_end &&
          (btn_poss_swap || btn_shot_rst)) begin
         shot_d = SHOT_W'(SHOT_SEC);
         if (btn_poss_swap) poss_d = ~poss_d;
      end

      running_d = (state_d == StRun);
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         game_q    <= SEC_W'(QUARTER_SEC);
         quarter_q <= QTR_W'(1);
         shot_q    <= SHOT_W'(SHOT_SEC);
         poss_q    <= 1'b0;
         viol_q    <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         game_q    <= game_d;
         quarter_q <= quarter_d;
         shot_q    <= shot_d;
         poss_q    <= poss_d;
         viol_q    <= viol_d;
         running_q <= running_d;
      end
   end

   buzzer_timer #(
      .BUZZ_SEC (BUZZ_SEC)
   ) u_buzzer_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .trigger  (buzz_trig),
      .tick_1hz (tick_1hz),
      .buzzer   (buzzer)
   );

   assign game_sec_left  = game_q;
   assign quarter        = quarter_q;
   assign shot_clock     = shot_q;
   assign poss_b         = poss_q;
   assign running        = running_q;
   assign shot_violation = viol_q;
   assign state          = state_q;

endmodule

// File: tb/tb_game_period_controller.sv
// Self-checking bench for game_period_controller: vector table, directed corner
// sequences and randomized stimulus against a behavioural game model.
module tb_game_period_controller;

   localparam int QS   = 5;
   localparam int NQ   = 4;
   localparam int BRK  = 2;
   localparam int SHOT = 3;
   localparam int OT   = 4;
   localparam int BUZZ = 2;

   localparam int S_IDLE  = 0;
   localparam int S_RUN   = 1;
   localparam int S_PAUSE = 2;
   localparam int S_BREAK = 3;
   localparam int S_FINAL = 4;

`ifdef GAME_OVERTIME_EN
   localparam bit OT_EN = 1'b1;
`else
   localparam bit OT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick_1hz = 1'b0;
   logic       btn_start = 1'b0;
   logic       btn_poss_swap = 1'b0;
   logic       btn_shot_rst = 1'b0;
   logic [7:0] score_a = 8'd0;
   logic [7:0] score_b = 8'd0;
   logic [9:0] game_sec_left;
   logic [2:0] quarter;
   logic [4:0] shot_clock;
   logic       poss_b;
   logic       running;
   logic       shot_violation;
   logic       buzzer;
   logic [2:0] state;

   int n_checks = 0;
   int n_err    = 0;

   // Behavioural model of the game.
   int m_state, m_game, m_qtr, m_shot, m_poss, m_viol, m_buzz;

   game_period_controller #(
      .QUARTER_SEC  (QS),
      .NUM_QUARTERS (NQ),
      .BREAK_SEC    (BRK),
      .SHOT_SEC     (SHOT),
      .OT_SEC       (OT),
      .BUZZ_SEC     (BUZZ)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .tick_1hz       (tick_1hz),
      .btn_start      (btn_start),
      .btn_poss_swap  (btn_poss_swap),
      .btn_shot_rst   (btn_shot_rst),
      .score_a        (score_a),
      .score_b        (score_b),
      .game_sec_left  (game_sec_left),
      .quarter        (quarter),
      .shot_clock     (shot_clock),
      .poss_b         (poss_b),
      .running        (running),
      .shot_violation (shot_violation),
      .buzzer         (buzzer),
      .state          (state)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_state = S_IDLE; m_game = QS; m_qtr = 1; m_shot = SHOT;
      m_poss = 0; m_viol = 0; m_buzz = 0;
   endtask

   // One clock of game rules given that cycle's pulses.
   task automatic model_step(input bit st, input bit sw, input bit sr, input bit tk);
      bit trig;
      bit pend;
      int prev;
      trig = 0; pend = 0; prev = m_state; m_viol = 0;
      if (prev == S_IDLE) begin
         if (st) m_state = S_RUN;
      end else if (prev == S_PAUSE) begin
         if (st) m_state = S_RUN;
      end else if (prev == S_RUN) begin
         if (st) m_state = S_PAUSE;
         else if (tk) begin
            if (m_game == 1) begin
               pend = 1; trig = 1; m_game = 0;
               m_shot = (m_shot > 0) ? m_shot - 1 : 0;
               if (m_qtr < NQ || (OT_EN && score_a == score_b)) begin
                  m_state = S_BREAK; m_game = BRK;
               end else m_state = S_FINAL;
            end else begin
               m_game = (m_game > 0) ? m_game - 1 : 0;
               if (m_shot == 1) begin
                  m_viol = 1; m_poss = 1 - m_poss; m_shot = SHOT; trig = 1;
                  m_state = S_PAUSE;
               end else m_shot = (m_shot > 0) ? m_shot - 1 : 0;
            end
         end
      end else if (prev == S_BREAK) begin
         if (tk) begin
            if (m_game == 1) begin
               m_poss  = m_qtr % 2;
               m_qtr   = (m_qtr < 7) ? m_qtr + 1 : 7;
               m_game  = (m_qtr > NQ) ? OT : QS;
               m_shot  = SHOT;
               m_state = S_PAUSE;
            end else m_game = m_game - 1;
         end
      end
      if ((prev == S_RUN || prev == S_PAUSE) && !pend && (sw || sr)) begin
         m_shot = SHOT;
         if (sw) m_poss = 1 - m_poss;
      end
      if (trig) m_buzz = BUZZ;
      else if (tk && m_buzz > 0) m_buzz--;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".state"},   int'(state),          m_state);
      chk({tag, ".game"},    int'(game_sec_left),  m_game);
      chk({tag, ".quarter"}, int'(quarter),        m_qtr);
      chk({tag, ".shot"},    int'(shot_clock),     m_shot);
      chk({tag, ".poss"},    int'(poss_b),         m_poss);
      chk({tag, ".viol"},    int'(shot_violation), m_viol);
      chk({tag, ".buzzer"},  int'(buzzer),         (m_buzz > 0) ? 1 : 0);
      chk({tag, ".running"}, int'(running),        (m_state == S_RUN) ? 1 : 0);
   endtask

   // Called just after an active edge; leaves time just after the next one.
   task automatic step(input string tag, input bit st, input bit sw, input bit sr,
                       input bit tk);
      btn_start = st; btn_poss_swap = sw; btn_shot_rst = sr; tick_1hz = tk;
      @(posedge clk);
      model_step(st, sw, sr, tk);
      #1;
      btn_start = 0; btn_poss_swap = 0; btn_shot_rst = 0; tick_1hz = 0;
      check_model(tag);
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #2;
      model_reset();
      check_model(tag);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic play_period(input string tag);
      step(tag, 1, 0, 0, 0);
      for (int i = 0; i < QS - 1; i++) begin
         step(tag, 0, 0, 0, 1);
         step(tag, 0, 0, 1, 0);
      end
      step(tag, 0, 0, 0, 1);
   endtask

   typedef struct {
      bit st, sw, sr, tk;
      int e_state, e_game, e_qtr, e_shot, e_poss, e_viol, e_buzz;
   } vec_t;

   vec_t tbl[16];

   initial begin
      //          st sw sr tk  state  game q shot poss viol buzz
      tbl[0]  = '{1, 0, 0, 0, S_RUN,   5, 1, 3, 0, 0, 0};
      tbl[1]  = '{0, 0, 0, 1, S_RUN,   4, 1, 2, 0, 0, 0};
      tbl[2]  = '{0, 0, 0, 1, S_RUN,   3, 1, 1, 0, 0, 0};
      tbl[3]  = '{0, 0, 0, 1, S_PAUSE, 2, 1, 3, 1, 1, 1};
      tbl[4]  = '{0, 0, 0, 0, S_PAUSE, 2, 1, 3, 1, 0, 1};
      tbl[5]  = '{0, 0, 0, 1, S_PAUSE, 2, 1, 3, 1, 0, 1};
      tbl[6]  = '{0, 0, 0, 1, S_PAUSE, 2, 1, 3, 1, 0, 0};
      tbl[7]  = '{0, 1, 0, 0, S_PAUSE, 2, 1, 3, 0, 0, 0};
      tbl[8]  = '{1, 0, 0, 0, S_RUN,   2, 1, 3, 0, 0, 0};
      tbl[9]  = '{1, 0, 0, 1, S_PAUSE, 2, 1, 3, 0, 0, 0};
      tbl[10] = '{1, 0, 0, 0, S_RUN,   2, 1, 3, 0, 0, 0};
      tbl[11] = '{0, 0, 0, 1, S_RUN,   1, 1, 2, 0, 0, 0};
      tbl[12] = '{0, 0, 0, 1, S_BREAK, 2, 1, 1, 0, 0, 1};
      tbl[13] = '{0, 1, 0, 0, S_BREAK, 2, 1, 1, 0, 0, 1};
      tbl[14] = '{0, 0, 0, 1, S_BREAK, 1, 1, 1, 0, 0, 1};
      tbl[15] = '{0, 0, 0, 1, S_PAUSE, 5, 2, 3, 1, 0, 0};

      // Reset values.
      model_reset();
      #12;
      chk("reset.state", int'(state), S_IDLE);
      chk("reset.game", int'(game_sec_left), QS);
      chk("reset.quarter", int'(quarter), 1);
      chk("reset.shot", int'(shot_clock), SHOT);
      chk("reset.poss", int'(poss_b), 0);
      chk("reset.outs", int'({running, shot_violation, buzzer}), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Vector table: violation, buzzer, pause-vs-tick, period end, break.
      for (int i = 0; i < 16; i++) begin
         btn_start = tbl[i].st; btn_poss_swap = tbl[i].sw;
         btn_shot_rst = tbl[i].sr; tick_1hz = tbl[i].tk;
         @(posedge clk);
         model_step(tbl[i].st, tbl[i].sw, tbl[i].sr, tbl[i].tk);
         #1;
         btn_start = 0; btn_poss_swap = 0; btn_shot_rst = 0; tick_1hz = 0;
         chk($sformatf("tbl%0d.state", i), int'(state), tbl[i].e_state);
         chk($sformatf("tbl%0d.game", i), int'(game_sec_left), tbl[i].e_game);
         chk($sformatf("tbl%0d.quarter", i), int'(quarter), tbl[i].e_qtr);
         chk($sformatf("tbl%0d.shot", i), int'(shot_clock), tbl[i].e_shot);
         chk($sformatf("tbl%0d.poss", i), int'(poss_b), tbl[i].e_poss);
         chk($sformatf("tbl%0d.viol", i), int'(shot_violation), tbl[i].e_viol);
         chk($sformatf("tbl%0d.buzzer", i), int'(buzzer), tbl[i].e_buzz);
         chk($sformatf("tbl%0d.running", i), int'(running),
             (tbl[i].e_state == S_RUN) ? 1 : 0);
      end

      // Period end coinciding with shot expiry: no violation.
      step("ovl", 1, 0, 0, 0);
      step("ovl", 0, 0, 0, 1);
      step("ovl", 0, 0, 0, 1);
      step("ovl", 0, 0, 1, 0);
      step("ovl", 0, 0, 0, 1);
      step("ovl", 0, 0, 0, 1);
      chk("ovl.pre_game", int'(game_sec_left), 1);
      chk("ovl.pre_shot", int'(shot_clock), 1);
      step("ovl", 0, 0, 0, 1);
      chk("ovl.no_viol", int'(shot_violation), 0);
      chk("ovl.break", int'(state), S_BREAK);
      chk("ovl.buzzer", int'(buzzer), 1);

      // Swap + shot reset together: single toggle plus reload.
      step("sws", 0, 0, 0, 1);
      step("sws", 0, 0, 0, 1);
      step("sws", 1, 0, 0, 0);
      step("sws", 0, 0, 0, 1);
      step("sws", 1, 0, 0, 0);
      chk("sws.pre_poss", int'(poss_b), 0);
      step("sws", 0, 1, 1, 0);
      chk("sws.poss", int'(poss_b), 1);
      chk("sws.shot", int'(shot_clock), SHOT);

      // Buttons ignored in IDLE.
      do_reset("rst1");
      step("idle", 0, 1, 0, 0);
      step("idle", 0, 0, 1, 0);
      chk("idle.poss", int'(poss_b), 0);

      // Regulation end on a tie.
      score_a = 8'd50; score_b = 8'd50;
      for (int q = 0; q < NQ - 1; q++) begin
         play_period("reg");
         step("reg", 0, 0, 0, 1);
         step("reg", 0, 0, 0, 1);
      end
      chk("reg.q4", int'(quarter), NQ);
      play_period("reg");
      chk("reg.end_state", int'(state), OT_EN ? S_BREAK : S_FINAL);
      if (OT_EN) begin
         step("ot", 0, 0, 0, 1);
         step("ot", 0, 0, 0, 1);
         chk("ot.quarter", int'(quarter), 5);
         chk("ot.game", int'(game_sec_left), OT);
      end else begin
         step("fin", 1, 1, 1, 1);
         chk("fin.stays", int'(state), S_FINAL);
      end

      // Asynchronous reset in the middle of RUN.
      do_reset("rst2");
      step("mid", 1, 0, 0, 0);
      step("mid", 0, 0, 0, 1);
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_model("midrst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Randomized play against the model.
      for (int n = 0; n < 3000; n++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r == 9) begin
            score_a = 8'd50;
            score_b = ($urandom_range(0, 1) == 0) ? 8'd50 : 8'd51;
         end
         if (m_state == S_FINAL && $urandom_range(0, 3) == 0) do_reset("rnd_rst");
         else step("rnd", r == 0, r == 1, r == 2, r >= 3 && r <= 6);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
